// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Top tag bits that mark RAM space when all ones
  localparam int MEM_SPACE_BITS = 7;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int pa, input int line_len);
    return pa - $clog2(line_len);
  endfunction

  function automatic int cnt_w(input int tmo);
    return (tmo > 0) ? $clog2(tmo + 1) : 1;
  endfunction

  localparam int DEF_NREQ = 3;
  localparam int DEF_TW   = tag_w(22, 4);
  localparam int DEF_IW   = idx_w(DEF_NREQ);

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational one-hot picker: scans req_i from start_i (round-robin) or 0 (fixed), with wrap.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic          rr_i,
  output logic [N-1:0]  oh_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin : pick_blk
    int base;
    int pos;
    oh_o  = '0;
    idx_o = '0;
    any_o = 1'b0;
    base  = rr_i ? int'(start_i) : 0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = base + k;
      if (pos >= N) pos = pos - N;
      if (!any_o && req_i[pos]) begin
        any_o     = 1'b1;
        oh_o[pos] = 1'b1;
        idx_o     = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates NREQ cache-line requesters onto one qspi memory port, with watchdog abort.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int  NREQ        = 3,
  parameter int  PA          = 22,
  parameter int  LINE_LENGTH = 4,
  parameter int  RR          = 1,
  parameter int  TMO         = 1023,
  localparam int TW          = tag_w(PA, LINE_LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      write,
  input  logic [NREQ*TW-1:0]   tag,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      fault,
  output logic [NREQ-1:0]      wstrobe,
  output logic [NREQ-1:0]      rstrobe,
  output logic                 q_req,
  output logic                 q_write,
  output logic                 q_i_d,
  output logic [TW-1:0]        q_tag,
  output logic                 q_mem,
  input  logic                 q_wstrobe,
  input  logic                 q_rstrobe,
  input  logic                 q_done
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(TMO);

  arb_state_e      state_q;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   rr_ptr_q;
  logic            q_req_q, q_write_q, q_i_d_q, q_mem_q;
  logic [TW-1:0]   q_tag_q;
  logic [CW-1:0]   wdog_q;

  logic [TW-1:0]   tag_a [NREQ];
  logic [IW-1:0]   start_d;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            busy, tmo_hit;

  for (genvar g = 0; g < NREQ; g++) begin : g_tag
    assign tag_a[g] = tag[g*TW +: TW];
  end

  // Pointer holds the last winner; reset value NREQ-1 makes channel 0 first.
  assign start_d = (rr_ptr_q == IW'(NREQ - 1)) ? '0 : rr_ptr_q + 1'b1;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i  (req),
    .start_i(start_d),
    .rr_i   (RR != 0),
    .oh_o   (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign busy    = (state_q == ST_BUSY);
  assign tmo_hit = (TMO != 0) && busy && (wdog_q == CW'(TMO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IW'(NREQ - 1);
      q_req_q   <= 1'b0;
      q_write_q <= 1'b0;
      q_i_d_q   <= 1'b0;
      q_mem_q   <= 1'b0;
      q_tag_q   <= '0;
      wdog_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (pick_any) begin
          state_q   <= ST_BUSY;
          grant_q   <= pick_oh;
          rr_ptr_q  <= pick_idx;
          q_req_q   <= 1'b1;
          q_write_q <= write[pick_idx];
          q_i_d_q   <= (pick_idx == '0);
          q_tag_q   <= tag_a[pick_idx];
          q_mem_q   <= &tag_a[pick_idx][TW-1 -: MEM_SPACE_BITS];
          wdog_q    <= '0;
        end
        ST_BUSY: begin
          // q_done takes precedence over a coincident timeout
          if (q_done || tmo_hit) begin
            state_q   <= ST_RELEASE;
            grant_q   <= '0;
            q_req_q   <= 1'b0;
            q_write_q <= 1'b0;
            q_i_d_q   <= 1'b0;
            q_mem_q   <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign done    = grant_q & {NREQ{busy & q_done}};
  assign fault   = grant_q & {NREQ{tmo_hit & ~q_done}};
  assign wstrobe = grant_q & {NREQ{busy & q_wstrobe}};
  assign rstrobe = grant_q & {NREQ{busy & q_rstrobe}};
  assign q_req   = q_req_q;
  assign q_write = q_write_q;
  assign q_i_d   = q_i_d_q;
  assign q_tag   = q_tag_q;
  assign q_mem   = q_mem_q;

endmodule
